// File: rtl/sipo_deser_pkg.sv
// -----------------------------------------------------------------------------
// sipo_deser_pkg
//   Shared types for the SPI read-path deserialiser.
//   - state_t : framing FSM states (IDLE waits for start, SHIFT collects bits)
//   - order_t : serial bit order of a frame
//   Also provides the frame-length clamp used when len_i is latched.
// -----------------------------------------------------------------------------
package sipo_deser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic {
    ORD_MSB_FIRST = 1'b0,
    ORD_LSB_FIRST = 1'b1
  } order_t;

  // A zero or oversized length is treated as a full-width frame.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/sipo_deser_bitcnt.sv
// -----------------------------------------------------------------------------
// sipo_bitcnt
//   Bit counter for one deserialiser frame.
//   Ports:
//     clk_i   in  1     system clock
//     rst_i   in  1     asynchronous active-high reset
//     clr_i   in  1     restart the count at zero (frame start)
//     inc_i   in  1     one bit taken this cycle
//     len_i   in  LenW  frame length, already clamped to 1..Width
//     cnt_o   out LenW  bits already taken in the current frame
//     last_o  out 1     the next bit taken completes the frame
// -----------------------------------------------------------------------------
module sipo_bitcnt #(
  parameter int unsigned LenW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic [LenW-1:0] len_i,
  output logic [LenW-1:0] cnt_o,
  output logic            last_o
);

  logic [LenW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + LenW'(1);
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = (r_cnt == (len_i - LenW'(1)));

endmodule

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
//   Serial-in/parallel-out deserialiser for the SPI read path. Frames 1..Width
//   bits (MSB- or LSB-first) from bit strobes and hands each completed frame,
//   right-aligned, to the consumer through a one-word valid/ready holding
//   register. A completion that finds the previous word unconsumed overwrites
//   it and sets the sticky overrun flag.
//   Ports:
//     clk_i        in  1      system clock
//     rst_i        in  1      asynchronous active-high reset
//     start_i      in  1      begin a new frame (aborts a frame in progress)
//     len_i        in  LenW   frame length, latched on start_i (0/>Width = Width)
//     lsb_first_i  in  1      bit order, latched on start_i (1 = LSB-first)
//     sample_i     in  1      din_i holds a valid bit this cycle
//     din_i        in  1      serial data
//     busy_o       out 1      frame in progress
//     dout_o       out Width  completed word, right-aligned
//     valid_o      out 1      dout_o holds an unconsumed word
//     ready_i      in  1      consumer takes dout_o when valid_o & ready_i
//     ovr_o        out 1      sticky overrun flag
//     clr_ovr_i    in  1      clears ovr_o (a coincident new overrun wins)
// -----------------------------------------------------------------------------
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned LenW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LenW-1:0]  len_i,
  input  logic             lsb_first_i,
  input  logic             sample_i,
  input  logic             din_i,
  output logic             busy_o,
  output logic [Width-1:0] dout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             ovr_o,
  input  logic             clr_ovr_i
);

  state_t           r_state;
  logic             r_busy;
  logic [Width-1:0] r_sr;
  logic [LenW-1:0]  r_len;
  order_t           r_order;
  logic [Width-1:0] r_dout;
  logic             r_valid;
  logic             r_ovr;

  logic [LenW-1:0]  w_len_clamped;
  logic [LenW-1:0]  w_cnt;
  logic             w_last;
  logic             w_take;
  logic             w_done;
  logic [Width-1:0] w_sr_nxt;

  assign w_len_clamped = LenW'(clamp_len(int'(len_i), Width));

  // start_i wins over a coincident strobe; that bit is dropped.
  assign w_take = sample_i & ~start_i & (r_state == ST_SHIFT);
  assign w_done = w_take & w_last;

  sipo_bitcnt #(
    .LenW (LenW)
  ) u_bitcnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_i),
    .inc_i  (w_take),
    .len_i  (r_len),
    .cnt_o  (w_cnt),
    .last_o (w_last)
  );

  // Next shift-register value including the current bit. MSB-first shifts
  // left, so a short frame ends up right-aligned because the register starts
  // cleared; LSB-first places each bit at its own position directly.
  always_comb begin
    w_sr_nxt = r_sr;
    if (r_order == ORD_MSB_FIRST) begin
      w_sr_nxt = {r_sr[Width-2:0], din_i};
    end else begin
      for (int unsigned i = 0; i < Width; i++) begin
        if (w_cnt == LenW'(i)) begin
          w_sr_nxt[i] = din_i;
        end
      end
    end
  end

  // Framing FSM and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_sr    <= '0;
      r_len   <= '0;
      r_order <= ORD_MSB_FIRST;
    end else begin
      if (start_i) begin
        r_state <= ST_SHIFT;
        r_busy  <= 1'b1;
        r_sr    <= '0;
        r_len   <= w_len_clamped;
        r_order <= order_t'(lsb_first_i);
      end else if (w_take) begin
        r_sr <= w_sr_nxt;
        if (w_last) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  // Output holding register, handshake and overrun flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_done) begin
        r_dout  <= w_sr_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_done && r_valid && !ready_i) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr_i) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign busy_o  = r_busy;
  assign dout_o  = r_dout;
  assign valid_o = r_valid;
  assign ovr_o   = r_ovr;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  len_i = '0;
  logic        lsb_first_i = 1'b0;
  logic        sample_i = 1'b0;
  logic        din_i = 1'b0;
  logic        busy_o;
  logic [15:0] dout_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        ovr_o;
  logic        clr_ovr_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  sipo_deser #(.Width(16), .LenW(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .lsb_first_i (lsb_first_i),
    .sample_i    (sample_i),
    .din_i       (din_i),
    .busy_o      (busy_o),
    .dout_o      (dout_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ovr_o       (ovr_o),
    .clr_ovr_i   (clr_ovr_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a frame is a list of received bits; the word is formed
  // from that list once it reaches the frame length.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;
  int          m_len = 0;
  logic        m_lsb = 1'b0;
  logic        m_bits[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_len = 0; m_lsb = 1'b0;
    m_bits.delete();
    exp_q.delete();
  endtask

  // Apply the effect of one clock edge, using the inputs held across it.
  task automatic model_edge();
    logic        done;
    logic        lost;
    logic [15:0] w;
    done = 1'b0;
    w = '0;
    if (start_i) begin
      m_busy = 1'b1;
      m_bits.delete();
      m_len = (len_i == 0 || int'(len_i) > 16) ? 16 : int'(len_i);
      m_lsb = lsb_first_i;
    end else if (sample_i && m_busy) begin
      m_bits.push_back(din_i);
      if (m_bits.size() == m_len) begin
        done = 1'b1;
        m_busy = 1'b0;
        for (int k = 0; k < m_len; k++) begin
          if (m_lsb) w[k] = m_bits[k];
          else       w[m_len-1-k] = m_bits[k];
        end
      end
    end
    lost = done && m_valid && !ready_i;
    if (clr_ovr_i) m_ovr = 1'b0;
    if (lost) begin
      m_ovr = 1'b1;
      void'(exp_q.pop_back());
    end
    if (done) begin
      exp_q.push_back(w);
      m_valid = 1'b1;
    end else if (m_valid && ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    start_i = 1'b0; sample_i = 1'b0; clr_ovr_i = 1'b0; ready_i = 1'b0;
  endtask

  // Stream bit k of the frame is v[nbits-1-k].
  task automatic frame(input int len_code, input int nbits, input logic lsb,
                       input logic [15:0] v, input logic rdy, input logic rdy_last,
                       input logic with_smp);
    start_i = 1'b1; len_i = 5'(len_code); lsb_first_i = lsb;
    sample_i = with_smp; din_i = 1'b1; ready_i = rdy; clr_ovr_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      sample_i = 1'b1;
      din_i = v[nbits-1-k];
      ready_i = (k == nbits-1) ? rdy_last : rdy;
      tick();
    end
    quiet();
  endtask

  task automatic drain();
    quiet();
    ready_i = 1'b1;
    tick();
    quiet();
  endtask

  // Monitor: flags and busy every cycle; words compared when consumed.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("valid", 16'(valid_o), 16'(m_valid));
      chk("ovr", 16'(ovr_o), 16'(m_ovr));
      chk("busy", 16'(busy_o), 16'(m_busy));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL word_unexpected: got %h expected none at %0t", dout_o, $time);
        end else begin
          chk("word", dout_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12 rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reset_dout", dout_o, 16'h0000);
    chk("reset_valid", 16'(valid_o), 16'h0);

    // 1. Reset mid-frame, then a stray strobe without start.
    start_i = 1'b1; len_i = 5'd16; lsb_first_i = 1'b0; tick();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin sample_i = 1'b1; din_i = 1'b1; tick(); end
    quiet();
    rst_i = 1'b1; model_reset();
    #2;
    chk("rst_busy", 16'(busy_o), 16'h0);
    chk("rst_valid", 16'(valid_o), 16'h0);
    chk("rst_ovr", 16'(ovr_o), 16'h0);
    chk("rst_dout", dout_o, 16'h0000);
    #4 rst_i = 1'b0;
    sample_i = 1'b1; din_i = 1'b1; tick();
    quiet(); tick();
    chk("stray_sample_valid", 16'(valid_o), 16'h0);

    // 2. Full-width MSB-first.
    frame(16, 16, 1'b0, 16'hA5C3, 1'b0, 1'b0, 1'b0);
    chk("msb16_dout", dout_o, 16'hA5C3);
    chk("msb16_valid", 16'(valid_o), 16'h1);
    drain();

    // 3. Short frames, both orders.
    frame(5, 5, 1'b1, 16'h0016, 1'b0, 1'b0, 1'b0);
    chk("lsb5_dout", dout_o, 16'h000D);
    drain();
    frame(5, 5, 1'b0, 16'h0016, 1'b0, 1'b0, 1'b0);
    chk("msb5_dout", dout_o, 16'h0016);
    drain();

    // 4. Overrun, then clear.
    frame(16, 16, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    frame(16, 16, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("ovr_dout", dout_o, 16'hBEEF);
    chk("ovr_set", 16'(ovr_o), 16'h1);
    clr_ovr_i = 1'b1; tick(); quiet();
    chk("ovr_clr", 16'(ovr_o), 16'h0);
    drain();

    // 5. Acceptance coinciding with completion.
    frame(8, 8, 1'b0, 16'h005A, 1'b0, 1'b0, 1'b0);
    frame(8, 8, 1'b0, 16'h00C3, 1'b0, 1'b1, 1'b0);
    chk("coinc_valid", 16'(valid_o), 16'h1);
    chk("coinc_ovr", 16'(ovr_o), 16'h0);
    chk("coinc_dout", dout_o, 16'h00C3);
    drain();
    chk("coinc_empty", 16'(valid_o), 16'h0);

    // 6. Abort, len 0, start+sample together.
    frame(16, 7, 1'b0, 16'h007F, 1'b0, 1'b0, 1'b0);
    chk("abort_no_valid", 16'(valid_o), 16'h0);
    frame(16, 16, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
    chk("abort_dout", dout_o, 16'h00FF);
    drain();
    frame(0, 16, 1'b0, 16'h3C5A, 1'b0, 1'b0, 1'b1);
    chk("len0_dout", dout_o, 16'h3C5A);
    drain();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start_i     = ($urandom_range(0, 24) == 0);
      len_i       = 5'($urandom_range(0, 31));
      lsb_first_i = 1'($urandom_range(0, 1));
      sample_i    = ($urandom_range(0, 2) != 0);
      din_i       = 1'($urandom_range(0, 1));
      ready_i     = ($urandom_range(0, 3) == 0);
      clr_ovr_i   = ($urandom_range(0, 15) == 0);
      tick();
    end
    quiet();
    drain();
    drain();
    chk("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
